// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - dual-issue instruction fetch queue with first-word fall-through dequeue
//
// Purpose:
//   Circular FIFO between a 2-wide fetch stage and a 2-wide decode stage.
//   Up to two instructions enter per cycle and up to two leave per cycle.
//
// Ports:
//   clk            system clock, rising edge
//   rst            asynchronous reset, active low
//   enq_valid0_i   fetch slot 0 (older) valid
//   enq_pc0_i      slot 0 PC
//   enq_instr0_i   slot 0 instruction word
//   enq_valid1_i   fetch slot 1 (younger) valid, only meaningful with slot 0
//   enq_pc1_i      slot 1 PC
//   enq_instr1_i   slot 1 instruction word
//   flush_i        redirect: discard every entry, ignore this cycle's traffic
//   deq_count_i    instructions consumed by decode this cycle (3 acts as 2)
//   deq_valid0_o   head entry present
//   deq_pc0_o      head PC (zero when invalid)
//   deq_instr0_o   head instruction (zero when invalid)
//   deq_valid1_o   head+1 entry present
//   deq_pc1_o      head+1 PC (zero when invalid)
//   deq_instr1_o   head+1 instruction (zero when invalid)
//   fetch_en_o     PC register enable, high while two or more entries are free
//   count_o        current occupancy
module fetch_queue #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     enq_valid0_i,
    input  logic [WIDTH-1:0]         enq_pc0_i,
    input  logic [WIDTH-1:0]         enq_instr0_i,
    input  logic                     enq_valid1_i,
    input  logic [WIDTH-1:0]         enq_pc1_i,
    input  logic [WIDTH-1:0]         enq_instr1_i,
    input  logic                     flush_i,
    input  logic [1:0]               deq_count_i,
    output logic                     deq_valid0_o,
    output logic [WIDTH-1:0]         deq_pc0_o,
    output logic [WIDTH-1:0]         deq_instr0_o,
    output logic                     deq_valid1_o,
    output logic [WIDTH-1:0]         deq_pc1_o,
    output logic [WIDTH-1:0]         deq_instr1_o,
    output logic                     fetch_en_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    // Highest occupancy that still leaves room for a full 2-wide fetch.
    localparam logic [CW-1:0] ENQ_LIMIT = CW'(DEPTH - 2);

    // Storage is deliberately unreset and separate from the pointers.
    logic [WIDTH-1:0] r_pc_mem    [DEPTH];
    logic [WIDTH-1:0] r_instr_mem [DEPTH];

    logic [AW-1:0] r_head;
    logic [AW-1:0] r_tail;
    logic [CW-1:0] r_count;

    logic          w_fetch_en;
    logic          w_enq0;
    logic          w_enq1;
    logic [1:0]    w_enq_n;
    logic [1:0]    w_deq_req;
    logic [1:0]    w_deq_n;
    logic [AW-1:0] w_head1;
    logic [AW-1:0] w_tail1;
    logic          w_valid0;
    logic          w_valid1;

    // Fetch enable looks only at the registered count so the PC enable never
    // depends combinationally on the decode stage.
    assign w_fetch_en = (r_count <= ENQ_LIMIT);

    // Slot 1 only counts when slot 0 is also present, keeping entries packed.
    assign w_enq0  = w_fetch_en & ~flush_i & enq_valid0_i;
    assign w_enq1  = w_enq0 & enq_valid1_i;
    assign w_enq_n = {1'b0, w_enq0} + {1'b0, w_enq1};

    assign w_deq_req = (deq_count_i == 2'd3) ? 2'd2 : deq_count_i;

    // Clamp the dequeue to what is present; when the clamp is active the
    // count is below 2, so its low bits hold the exact amount.
    always_comb begin
        w_deq_n = w_deq_req;
        if (CW'(w_deq_req) > r_count) begin
            w_deq_n = r_count[1:0];
        end
    end

    assign w_head1 = r_head + AW'(1);
    assign w_tail1 = r_tail + AW'(1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (flush_i) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            r_head  <= r_head + AW'(w_deq_n);
            r_tail  <= r_tail + AW'(w_enq_n);
            r_count <= r_count + CW'(w_enq_n) - CW'(w_deq_n);
        end
    end

    always_ff @(posedge clk) begin
        if (w_enq0) begin
            r_pc_mem[r_tail]    <= enq_pc0_i;
            r_instr_mem[r_tail] <= enq_instr0_i;
        end
        if (w_enq1) begin
            r_pc_mem[w_tail1]    <= enq_pc1_i;
            r_instr_mem[w_tail1] <= enq_instr1_i;
        end
    end

    // First-word fall-through: head entries read straight from storage,
    // masked to zero when not present.
    assign w_valid0 = (r_count != '0);
    assign w_valid1 = (r_count >= CW'(2));

    assign deq_valid0_o = w_valid0;
    assign deq_valid1_o = w_valid1;
    assign deq_pc0_o    = w_valid0 ? r_pc_mem[r_head]     : '0;
    assign deq_instr0_o = w_valid0 ? r_instr_mem[r_head]  : '0;
    assign deq_pc1_o    = w_valid1 ? r_pc_mem[w_head1]    : '0;
    assign deq_instr1_o = w_valid1 ? r_instr_mem[w_head1] : '0;
    assign fetch_en_o   = w_fetch_en;
    assign count_o      = r_count;

endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - scoreboard bench for fetch_queue with a queue-based reference model
module tb_fetch_queue;

    localparam int WIDTH = 32;
    localparam int DEPTH = 8;

    typedef struct packed {
        logic [WIDTH-1:0] pc;
        logic [WIDTH-1:0] instr;
    } ent_t;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              enq_valid0_i = 1'b0;
    logic [WIDTH-1:0]  enq_pc0_i = '0;
    logic [WIDTH-1:0]  enq_instr0_i = '0;
    logic              enq_valid1_i = 1'b0;
    logic [WIDTH-1:0]  enq_pc1_i = '0;
    logic [WIDTH-1:0]  enq_instr1_i = '0;
    logic              flush_i = 1'b0;
    logic [1:0]        deq_count_i = 2'd0;
    logic              deq_valid0_o;
    logic [WIDTH-1:0]  deq_pc0_o;
    logic [WIDTH-1:0]  deq_instr0_o;
    logic              deq_valid1_o;
    logic [WIDTH-1:0]  deq_pc1_o;
    logic [WIDTH-1:0]  deq_instr1_o;
    logic              fetch_en_o;
    logic [$clog2(DEPTH):0] count_o;

    fetch_queue #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .enq_valid0_i (enq_valid0_i),
        .enq_pc0_i    (enq_pc0_i),
        .enq_instr0_i (enq_instr0_i),
        .enq_valid1_i (enq_valid1_i),
        .enq_pc1_i    (enq_pc1_i),
        .enq_instr1_i (enq_instr1_i),
        .flush_i      (flush_i),
        .deq_count_i  (deq_count_i),
        .deq_valid0_o (deq_valid0_o),
        .deq_pc0_o    (deq_pc0_o),
        .deq_instr0_o (deq_instr0_o),
        .deq_valid1_o (deq_valid1_o),
        .deq_pc1_o    (deq_pc1_o),
        .deq_instr1_o (deq_instr1_o),
        .fetch_en_o   (fetch_en_o),
        .count_o      (count_o)
    );

    always #5 clk = ~clk;

    // Expected queue contents after the most recent edge, oldest first.
    ent_t mq[$];
    int   n_vec = 0;
    int   n_err = 0;
    bit   mon_en = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Apply one cycle of stimulus at the falling edge and record the
    // expected effect of the following rising edge in the model.
    task automatic cycle(input bit v0, input logic [WIDTH-1:0] pc0, input logic [WIDTH-1:0] i0,
                         input bit v1, input logic [WIDTH-1:0] pc1, input logic [WIDTH-1:0] i1,
                         input bit fl, input logic [1:0] dc);
        int  dn;
        bit  fe;
        ent_t e;
        @(negedge clk);
        enq_valid0_i = v0;  enq_pc0_i = pc0;  enq_instr0_i = i0;
        enq_valid1_i = v1;  enq_pc1_i = pc1;  enq_instr1_i = i1;
        flush_i      = fl;  deq_count_i = dc;
        fe = (DEPTH - mq.size()) >= 2;
        if (fl) begin
            mq.delete();
        end else begin
            dn = (dc == 2'd3) ? 2 : int'(dc);
            if (dn > mq.size()) dn = mq.size();
            repeat (dn) e = mq.pop_front();
            if (fe && v0) begin
                mq.push_back('{pc: pc0, instr: i0});
                if (v1) mq.push_back('{pc: pc1, instr: i1});
            end
        end
    endtask

    task automatic idle();
        cycle(1'b0, '0, '0, 1'b0, '0, '0, 1'b0, 2'd0);
    endtask

    task automatic flush_q();
        cycle(1'b0, '0, '0, 1'b0, '0, '0, 1'b1, 2'd0);
    endtask

    task automatic after_edge();
        @(posedge clk);
        #2;
    endtask

    // Monitor: compares every visible output against the model head.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (mon_en) begin
                chk("count", 64'(count_o), 64'(mq.size()));
                chk("fetch_en", 64'(fetch_en_o), 64'((DEPTH - mq.size()) >= 2));
                chk("valid0", 64'(deq_valid0_o), 64'(mq.size() >= 1));
                chk("valid1", 64'(deq_valid1_o), 64'(mq.size() >= 2));
                chk("slot0", {deq_pc0_o, deq_instr0_o},
                    (mq.size() >= 1) ? {mq[0].pc, mq[0].instr} : 64'h0);
                chk("slot1", {deq_pc1_o, deq_instr1_o},
                    (mq.size() >= 2) ? {mq[1].pc, mq[1].instr} : 64'h0);
            end
        end
    end

    initial begin
        logic [WIDTH-1:0] pc;
        #12;
        chk("rst_count", 64'(count_o), 64'h0);
        chk("rst_valid", {62'h0, deq_valid1_o, deq_valid0_o}, 64'h0);
        chk("rst_data", 64'(deq_pc0_o | deq_instr0_o | deq_pc1_o | deq_instr1_o), 64'h0);
        chk("rst_fetch_en", 64'(fetch_en_o), 64'h1);
        @(negedge clk);
        rst = 1'b1;
        mon_en = 1'b1;

        // Basic pair, enqueued on the first edge after reset release.
        cycle(1'b1, 32'h00, 32'h13, 1'b1, 32'h04, 32'h93, 1'b0, 2'd0);
        after_edge();
        chk("pair_count", 64'(count_o), 64'd2);
        chk("pair_pc0", {63'h0, deq_valid0_o} << 32 | 64'(deq_pc0_o), 64'h1_0000_0000);
        chk("pair_pc1", {63'h0, deq_valid1_o} << 32 | 64'(deq_pc1_o), 64'h1_0000_0004);

        // Fill to full, then one more attempt.
        flush_q();
        pc = 32'h100;
        for (int c = 0; c < 5; c++) begin
            cycle(1'b1, pc, $urandom, 1'b1, pc + 4, $urandom, 1'b0, 2'd0);
            pc += 8;
            after_edge();
            if (c == 2) begin
                chk("fill3_count", 64'(count_o), 64'd6);
                chk("fill3_fe", 64'(fetch_en_o), 64'd1);
            end else if (c == 3) begin
                chk("fill4_count", 64'(count_o), 64'd8);
                chk("fill4_fe", 64'(fetch_en_o), 64'd0);
            end else if (c == 4) begin
                chk("full_hold", 64'(count_o), 64'd8);
            end
        end

        // Full queue: dequeue 2 opens space, then dequeue 2 while enqueueing 2.
        cycle(1'b0, '0, '0, 1'b0, '0, '0, 1'b0, 2'd2);
        cycle(1'b1, pc, 32'hA, 1'b1, pc + 4, 32'hB, 1'b0, 2'd2);
        after_edge();
        chk("swap_count", 64'(count_o), 64'd6);

        // Over-dequeue.
        flush_q();
        cycle(1'b1, 32'h200, 32'h1, 1'b1, 32'h204, 32'h2, 1'b0, 2'd0);
        cycle(1'b0, '0, '0, 1'b0, '0, '0, 1'b0, 2'd1);
        after_edge();
        chk("od_pre", 64'(count_o), 64'd1);
        cycle(1'b0, '0, '0, 1'b0, '0, '0, 1'b0, 2'd2);
        after_edge();
        chk("od_count", 64'(count_o), 64'd0);
        chk("od_valid", {62'h0, deq_valid1_o, deq_valid0_o}, 64'h0);

        // Flush priority over enqueue and dequeue.
        flush_q();
        cycle(1'b1, 32'h300, 32'h1, 1'b1, 32'h304, 32'h2, 1'b0, 2'd0);
        cycle(1'b1, 32'h308, 32'h3, 1'b1, 32'h30c, 32'h4, 1'b0, 2'd0);
        cycle(1'b1, 32'h310, 32'h5, 1'b0, 32'h314, 32'h6, 1'b0, 2'd0);
        after_edge();
        chk("fp_pre", 64'(count_o), 64'd5);
        cycle(1'b1, 32'h318, 32'h7, 1'b1, 32'h31c, 32'h8, 1'b1, 2'd1);
        after_edge();
        chk("fp_count", 64'(count_o), 64'd0);
        chk("fp_fe", 64'(fetch_en_o), 64'd1);

        // Wrap-around with sequential PCs.
        pc = 32'h0;
        for (int c = 0; c < 10; c++) begin
            cycle(1'b1, pc, $urandom, 1'b1, pc + 4, $urandom, 1'b0, 2'd2);
            pc += 8;
        end
        cycle(1'b0, '0, '0, 1'b0, '0, '0, 1'b0, 2'd0);
        after_edge();
        chk("wrap_pc0", 64'(deq_pc0_o), 64'h48);
        chk("wrap_pc1", 64'(deq_pc1_o), 64'h4c);

        // Asynchronous reset between edges with four entries held.
        flush_q();
        cycle(1'b1, 32'h400, 32'h1, 1'b1, 32'h404, 32'h2, 1'b0, 2'd0);
        cycle(1'b1, 32'h408, 32'h3, 1'b1, 32'h40c, 32'h4, 1'b0, 2'd0);
        idle();
        #2;
        chk("ar_pre", 64'(count_o), 64'd4);
        rst = 1'b0;
        mq.delete();
        #1;
        chk("ar_count", 64'(count_o), 64'd0);
        chk("ar_valid0", 64'(deq_valid0_o), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        cycle(1'b1, 32'h500, 32'h9, 1'b0, '0, '0, 1'b0, 2'd0);
        after_edge();
        chk("post_rst_enq", 64'(count_o), 64'd1);

        // Randomized traffic.
        for (int c = 0; c < 600; c++) begin
            cycle(1'($urandom), $urandom, $urandom, 1'($urandom), $urandom, $urandom,
                  ($urandom_range(0, 19) == 0), 2'($urandom));
        end
        idle();
        after_edge();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 The module SHALL have parameter WIDTH, default 32, meaning the PC and instruction word width.
REQ-002 The module SHALL have parameter DEPTH, default 8, meaning the number of entries; it is a power of two and at least 4.
REQ-003 The module SHALL have port clk, input, 1 bit: the single system clock, rising-edge active.
REQ-004 The module SHALL have port rst, input, 1 bit: asynchronous, active-low reset, where 0 means in reset.
REQ-005 The module SHALL have port enq_valid0_i, input, 1 bit: fetch slot 0 carries an instruction (older slot).
REQ-006 The module SHALL have ports enq_pc0_i and enq_instr0_i, input, WIDTH bits each: PC and instruction word of slot 0.
REQ-007 The module SHALL have port enq_valid1_i, input, 1 bit: fetch slot 1 carries an instruction (younger slot).
REQ-008 The module SHALL have ports enq_pc1_i and enq_instr1_i, input, WIDTH bits each: PC and instruction word of slot 1.
REQ-009 The module SHALL have port flush_i, input, 1 bit: mispredict or predict redirect; discard all entries.
REQ-010 The module SHALL have port deq_count_i, input, 2 bits: number of instructions decode consumes this cycle (0, 1 or 2).
REQ-011 The module SHALL have ports deq_valid0_o and deq_valid1_o, output, 1 bit each: head and head+1 entries present.
REQ-012 The module SHALL have ports deq_pc0_o, deq_instr0_o, deq_pc1_o and deq_instr1_o, output, WIDTH bits each: head and head+1 entry contents.
REQ-013 The module SHALL have port fetch_en_o, output, 1 bit: enable to the PC register; high when at least 2 entries are free.
REQ-014 The module SHALL have port count_o, output, $clog2(DEPTH)+1 bits: current occupancy.

Function
REQ-015 The queue SHALL be a circular FIFO with registered head pointer, tail pointer and count; pointers wrap modulo DEPTH.
REQ-016 fetch_en_o SHALL equal (DEPTH - count) >= 2, computed from the registered count only and not from same-cycle dequeue.
REQ-017 Enqueue SHALL occur at the clock edge only when fetch_en_o is high and flush_i is low.
REQ-018 When enqueue occurs, enq_valid0_i SHALL write slot 0 at tail, and enq_valid1_i together with enq_valid0_i SHALL write slot 1 at tail+1; enq_n is 0, 1 or 2.
REQ-019 enq_valid1_i SHALL be ignored whenever enq_valid0_i is low.
REQ-020 enq_valid inputs presented while fetch_en_o is low SHALL be dropped without state change; upstream holds them via the PC enable.
REQ-021 The dequeue amount deq_n SHALL be min(deq_count_i, valid entries), with a deq_count_i value of 3 treated as 2; the head advances by deq_n.
REQ-022 Dequeue output ports SHALL be combinational from storage at head and head+1 (first-word fall-through).
REQ-023 An entry written at edge N SHALL be visible on the outputs in the cycle after edge N.
REQ-024 deq_valid0_o SHALL equal (count >= 1) and deq_valid1_o SHALL equal (count >= 2).
REQ-025 The PC and instruction outputs of an invalid slot SHALL be driven to zero.
REQ-026 For simultaneous enqueue and dequeue, count_next SHALL equal count + enq_n - deq_n.
REQ-027 Storage SHALL be separate from the pointers, so that a full queue dequeuing 2 while enqueuing 2 is legal once fetch_en_o is high.
REQ-028 When flush_i is high at an edge, head, tail and count SHALL become 0, and enqueue and dequeue in that cycle SHALL be ignored.
REQ-029 Flush SHALL take priority over every other event.
REQ-030 Program order SHALL be preserved: deq slot 0 is always older than deq slot 1, and wrap-around does not reorder entries.
REQ-031 count SHALL never exceed DEPTH or underflow below 0 under any input combination.

Reset
REQ-032 Assertion of rst low SHALL immediately, without waiting for a clock, force head, tail and count to 0.
REQ-033 While in reset, deq_valid0_o and deq_valid1_o SHALL be 0, all deq data outputs 0, count_o 0, and fetch_en_o 1.
REQ-034 Storage contents SHALL not require reset.
REQ-035 Reset asserted mid-operation SHALL discard all entries, with the same effect as a flush but asynchronous.
REQ-036 After rst deasserts, the first rising edge SHALL accept enqueue normally.

Verification
REQ-037 Basic pair: enqueue pc0=0x00/instr0=0x13 and pc1=0x04/instr1=0x93 with deq_count_i=0 -> the next cycle shows count_o=2, deq_valid0_o=1 with pc 0x00, and deq_valid1_o=1 with pc 0x04.
REQ-038 Fill to full (DEPTH=8): enqueue 2 per cycle with no dequeue for 3 cycles -> count_o=6 and fetch_en_o=1; after a 4th cycle count_o=8 and fetch_en_o=0; a further enqueue attempt leaves count_o=8.
REQ-039 Wrap-around: with repeated enqueue 2 / dequeue 2 traffic for 10 cycles using PCs 0x00, 0x04, 0x08, ... -> dequeued PCs are strictly sequential, with no loss or duplication across the pointer wrap.
REQ-040 Over-dequeue: with count_o=1 and deq_count_i=2 -> count_o=0 next cycle, and deq_valid0_o=0 and deq_valid1_o=0.
REQ-041 Flush priority: with count_o=5, flush_i=1 together with enqueue 2 and deq_count_i=1 -> count_o=0 next cycle and fetch_en_o=1.
REQ-042 Asynchronous reset: with count_o=4, pull rst low between clock edges -> count_o=0 and deq_valid0_o=0 before the next edge.
